mat2x2_result_serializer: RTL and testbench

//   Output end of the 2x2 matrix datapath: accepts one packed 2x2 result word
//   {m11,m12,m21,m22} (m11 in [31:24]) and streams its four 8-bit elements over a

---
 rtl/mat2x2_result_serializer_pkg.sv | 25 ++
 rtl/mat2x2_result_serializer.sv | 103 ++++++++++
 tb/tb_mat2x2_result_serializer.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mat2x2_result_serializer_pkg.sv
// Shared definitions for the 2x2 matrix result serializer.
// Holds the default element width, the element count, FSM state encodings
// and the slice positions of each matrix element inside the packed word.
// Optional feature macro used by the top: MAT_SER_TRANSPOSE_EN.
package mat2x2_result_serializer_pkg;

    localparam int ELEM_W_DEF = 8;
    localparam int NUM_ELEM   = 4;

    // Beat index of the final element of a matrix
    localparam logic [1:0] IDX_LAST = 2'(NUM_ELEM - 1);

    // Slice positions inside {m11,m12,m21,m22}: element at position p
    // occupies word[p*ELEM_W +: ELEM_W], so m11 sits in the top slice.
    localparam int POS_M11 = 3;
    localparam int POS_M12 = 2;
    localparam int POS_M21 = 1;
    localparam int POS_M22 = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

endpackage

// File: rtl/mat2x2_result_serializer.sv
// 2x2 matrix result serializer.
// Captures one packed word {m11,m12,m21,m22} and streams its four elements
// over a valid/ready byte interface, one element per accepted beat, with
// beat index and last flag. A new word can be taken in the same cycle the
// last beat of the current one is accepted, giving bubble-free streaming.
// Optional feature macro: MAT_SER_TRANSPOSE_EN -- when defined, elements
// are emitted column-major (m11,m21,m12,m22); otherwise row-major.
module mat2x2_result_serializer
    import mat2x2_result_serializer_pkg::*;
#(
    parameter int ELEM_W = ELEM_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_ELEM*ELEM_W-1:0]   in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [ELEM_W-1:0]            out_data,
    output logic [1:0]                   out_idx,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last,
    output logic                         busy
);

    state_t                       state;
    logic [1:0]                   idx;
    logic [NUM_ELEM*ELEM_W-1:0]   held;
    logic                         vld;
    logic                         accept;
    logic                         last_beat;
    logic [ELEM_W-1:0]            elem;

    assign accept    = vld & out_ready;
    assign last_beat = vld & (idx == IDX_LAST);

    // A word can enter when idle, or when the final beat leaves this cycle
    assign in_ready  = (state == ST_IDLE) | (accept & last_beat);

    assign out_idx   = idx;
    assign out_valid = vld;
    assign out_last  = last_beat;
    assign busy      = (state == ST_SEND);

    // Element select: map beat index to a slice of the held word
    always_comb begin
        elem = '0;
        case (idx)
`ifdef MAT_SER_TRANSPOSE_EN
            2'd0:    elem = held[POS_M11*ELEM_W +: ELEM_W];
            2'd1:    elem = held[POS_M21*ELEM_W +: ELEM_W];
            2'd2:    elem = held[POS_M12*ELEM_W +: ELEM_W];
            default: elem = held[POS_M22*ELEM_W +: ELEM_W];
`else
            2'd0:    elem = held[POS_M11*ELEM_W +: ELEM_W];
            2'd1:    elem = held[POS_M12*ELEM_W +: ELEM_W];
            2'd2:    elem = held[POS_M21*ELEM_W +: ELEM_W];
            default: elem = held[POS_M22*ELEM_W +: ELEM_W];
`endif
        endcase
    end

    // Present zero on the data bus whenever no element is being offered
    assign out_data = vld ? elem : '0;

    // Control FSM: capture word, step beat index on accept, chain next word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            idx   <= '0;
            held  <= '0;
            vld   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        held  <= in_data;
                        idx   <= '0;
                        vld   <= 1'b1;
                        state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (accept) begin
                        if (idx == IDX_LAST) begin
                            idx <= '0;
                            if (in_valid) begin
                                // Back-to-back word: stay in SEND, restart at beat 0
                                held <= in_data;
                            end else begin
                                vld   <= 1'b0;
                                state <= ST_IDLE;
                            end
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mat2x2_result_serializer.sv
// Self-checking bench for mat2x2_result_serializer.
// Expected element order follows MAT_SER_TRANSPOSE_EN when it is defined.
module tb_mat2x2_result_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_idx;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mat2x2_result_serializer #(.ELEM_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy)
    );

    // Element emitted at beat k for packed word {m11,m12,m21,m22}
    function automatic logic [7:0] elem_of(input logic [31:0] w, input int k);
`ifdef MAT_SER_TRANSPOSE_EN
        case (k)
            0:       return w[31:24];
            1:       return w[15:8];
            2:       return w[23:16];
            default: return w[7:0];
        endcase
`else
        case (k)
            0:       return w[31:24];
            1:       return w[23:16];
            2:       return w[15:8];
            default: return w[7:0];
        endcase
`endif
    endfunction

    // Observed vector: {out_valid, out_data, out_idx, out_last, busy, in_ready}
    function automatic logic [13:0] observe();
        return {out_valid, out_data, out_idx, out_last, busy, in_ready};
    endfunction

    task automatic test_reset();
        logic [13:0] got;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        got = observe();
        n_tests++;
        if (got !== 14'b0_00000000_00_0_0_1) begin
            n_fail++;
            $display("FAIL reset_state: got %h required %h", got, 14'b0_00000000_00_0_0_1);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_idle();
        logic [13:0] got;
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_data = 32'hA5A50000 | 32'(c);
            @(negedge clk);
            got = observe();
            n_tests++;
            if ({got[13], got[1], got[0]} !== 3'b001) begin
                n_fail++;
                $display("FAIL idle_cycle%0d: got valid/busy/in_ready %b required 001", c, {got[13], got[1], got[0]});
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_single();
        logic [7:0]  exp [4];
        logic [13:0] got;
        logic [13:0] req;
`ifdef MAT_SER_TRANSPOSE_EN
        exp = '{8'h13, 8'h2B, 8'h16, 8'h32};
`else
        exp = '{8'h13, 8'h16, 8'h2B, 8'h32};
`endif
        in_data = 32'h13162B32; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL single_pre: got in_ready/out_valid %b required 10", {in_ready, out_valid});
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            got = observe();
            req = {1'b1, exp[k], 2'(k), k == 3, 1'b1, k == 3};
            n_tests++;
            if (got !== req) begin
                n_fail++;
                $display("FAIL single_beat%0d: got %h required %h", k, got, req);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        got = observe();
        n_tests++;
        if (got !== 14'b0_00000000_00_0_0_1) begin
            n_fail++;
            $display("FAIL single_post: got %h required %h", got, 14'b0_00000000_00_0_0_1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        logic [31:0] w;
        logic [13:0] got;
        logic [13:0] req;
        int k;
        int cyc;
        w = 32'h11223344; k = 0; cyc = 0;
        in_data = w; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        while (k < 4 && cyc < 30) begin
            out_ready = (cyc % 3 == 0);
            in_valid  = (k < 3);
            in_data   = 32'hF0F0F0F0 ^ 32'(cyc);
            @(negedge clk);
            got = observe();
            req = {1'b1, elem_of(w, k), 2'(k), k == 3, 1'b1, out_ready && (k == 3)};
            n_tests++;
            if (got !== req) begin
                n_fail++;
                $display("FAIL stall_cyc%0d_beat%0d: got %h required %h", cyc, k, got, req);
            end
            @(posedge clk); #1;
            if (out_ready) k++;
            cyc++;
        end
        n_tests++;
        if (k != 4) begin
            n_fail++;
            $display("FAIL stall_timeout: got beats %0d required 4", k);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({out_valid, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL stall_post: got valid/busy %b required 00", {out_valid, busy});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] w;
        logic [13:0] got;
        logic [13:0] req;
        in_data = 32'h01020304; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        for (int b = 0; b < 8; b++) begin
            in_valid = (b == 3);
            in_data  = (b == 3) ? 32'h05060708 : 32'hDEADBEEF;
            w        = (b < 4) ? 32'h01020304 : 32'h05060708;
            @(negedge clk);
            got = observe();
            req = {1'b1, elem_of(w, b % 4), 2'(b % 4), (b % 4) == 3, 1'b1, (b % 4) == 3};
            n_tests++;
            if (got !== req) begin
                n_fail++;
                $display("FAIL b2b_beat%0d: got %h required %h", b, got, req);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({out_valid, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL b2b_post: got valid/busy %b required 00", {out_valid, busy});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        logic [13:0] got;
        logic [13:0] req;
        in_data = 32'h12345678; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_tests++;
        if (out_idx !== 2'd2) begin
            n_fail++;
            $display("FAIL areset_pre_idx: got %0d required 2", out_idx);
        end
        #2;
        rst = 1'b1;
        #1;
        got = observe();
        n_tests++;
        if (got !== 14'b0_00000000_00_0_0_1) begin
            n_fail++;
            $display("FAIL areset_outputs: got %h required %h", got, 14'b0_00000000_00_0_0_1);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        in_data = 32'hAABBCCDD; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            got = observe();
            req = {1'b1, elem_of(32'hAABBCCDD, k), 2'(k), k == 3, 1'b1, k == 3};
            n_tests++;
            if (got !== req) begin
                n_fail++;
                $display("FAIL areset_beat%0d: got %h required %h", k, got, req);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_idle();
        test_single();
        test_stall();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
